// File: rtl/seq_alu.sv
// Registered multi-cycle ALU: single-cycle logic/compare/shift ops plus iterative
// unsigned multiply (shift-add) and divide (restoring) behind a start/busy/done handshake.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALU_result,
    output logic [WIDTH-1:0] ALU_result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             illegal,
    output logic             busy,
    output logic             done
);

    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("seq_alu: WIDTH must be a power of two and at least 4");
    end

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MULU = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t           state;
    logic [SHW-1:0]   cnt;

    logic [3:0]       op_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [WIDTH-1:0] acc_hi_p1;
    logic [WIDTH-1:0] acc_lo_p1;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [SHW-1:0]          shamt;
    logic [WIDTH-1:0]        sum;
    logic [WIDTH-1:0]        diff;

    logic [WIDTH-1:0] sc_lo;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_ovf;
    logic             sc_dbz;
    logic             sc_ill;

    logic             iter;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_t;
    logic [WIDTH:0]   div_d;
    logic             div_ok;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x, input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Subtraction flips B's sign, so overflow needs operands of opposite sign.
    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x, input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    assign a_s   = a_p0;
    assign b_s   = b_p0;
    assign shamt = b_p0[SHW-1:0];
    assign sum   = a_p0 + b_p0;
    assign diff  = a_p0 - b_p0;
    assign iter  = (op_p0 == OP_MULU) || ((op_p0 == OP_DIVU) && (b_p0 != '0));

    always_comb begin
        sc_lo  = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        sc_dbz = 1'b0;
        sc_ill = 1'b0;
        case (op_p0)
            OP_ADD: begin
                sc_lo  = sum;
                sc_ovf = add_ovf(a_p0, b_p0, sum);
            end
            OP_SUB: begin
                sc_lo  = diff;
                sc_ovf = sub_ovf(a_p0, b_p0, diff);
            end
            OP_AND:  sc_lo = a_p0 & b_p0;
            OP_OR:   sc_lo = a_p0 | b_p0;
            OP_NOR:  sc_lo = ~(a_p0 | b_p0);
            OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: sc_lo = {{(WIDTH-1){1'b0}}, (a_p0 < b_p0)};
            OP_SLL:  sc_lo = a_p0 << shamt;
            OP_SRL:  sc_lo = a_p0 >> shamt;
            OP_SRA:  sc_lo = a_s >>> shamt;
            OP_MULU: ;
            // Only reached with B==0; a nonzero divisor takes the iterative path.
            OP_DIVU: begin
                sc_lo  = '1;
                sc_hi  = a_p0;
                sc_dbz = 1'b1;
            end
            default: sc_ill = 1'b1;
        endcase
    end

    // One shift-add (LSB first) or one restoring-divide (MSB first) iteration.
    always_comb begin
        mul_sum = {1'b0, acc_hi_p1} + (acc_lo_p1[0] ? {1'b0, a_p0} : {(WIDTH+1){1'b0}});
        div_t   = {acc_hi_p1, acc_lo_p1[WIDTH-1]};
        div_d   = div_t - {1'b0, b_p0};
        div_ok  = ~div_d[WIDTH];
        if (op_p0 == OP_MULU) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_p1[WIDTH-1:1]};
        end else begin
            step_hi = div_ok ? div_d[WIDTH-1:0] : div_t[WIDTH-1:0];
            step_lo = {acc_lo_p1[WIDTH-2:0], div_ok};
        end
    end

    // Stage p0: operand capture at accept; stage p1: iteration accumulator.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            op_p0     <= ALU_control;
            a_p0      <= A;
            b_p0      <= B;
            acc_hi_p1 <= '0;
            acc_lo_p1 <= (ALU_control == OP_MULU) ? B : A;
        end else if (state == S_EXEC) begin
            acc_hi_p1 <= step_hi;
            acc_lo_p1 <= step_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            ALU_result    <= '0;
            ALU_result_hi <= '0;
            zero          <= 1'b0;
            overflow      <= 1'b0;
            div_by_zero   <= 1'b0;
            illegal       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_EXEC;
                        busy  <= 1'b1;
                        cnt   <= SHW'(WIDTH - 1);
                    end
                end
                S_EXEC: begin
                    if (iter && cnt != '0) begin
                        cnt <= cnt - SHW'(1);
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        cnt   <= '0;
                        if (iter) begin
                            ALU_result    <= step_lo;
                            ALU_result_hi <= step_hi;
                            zero          <= (step_lo == '0);
                            overflow      <= 1'b0;
                            div_by_zero   <= 1'b0;
                            illegal       <= 1'b0;
                        end else begin
                            ALU_result    <= sc_lo;
                            ALU_result_hi <= sc_hi;
                            zero          <= (sc_lo == '0);
                            overflow      <= sc_ovf;
                            div_by_zero   <= sc_dbz;
                            illegal       <= sc_ill;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: 32-bit instance for the full op set, 16-bit instance for MULU.
module tb_seq_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start32;
    logic [3:0]  op32;
    logic [31:0] a32, b32, r32, h32;
    logic        z32, o32, dz32, il32, busy32, done32;

    logic        start16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, r16, h16;
    logic        z16, o16, dz16, il16, busy16, done16;

    int checks = 0;
    int errors = 0;
    int lat;
    int bcnt;
    int dcnt;

    seq_alu #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .start(start32), .ALU_control(op32), .A(a32), .B(b32),
        .ALU_result(r32), .ALU_result_hi(h32), .zero(z32), .overflow(o32),
        .div_by_zero(dz32), .illegal(il32), .busy(busy32), .done(done32)
    );

    seq_alu #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .ALU_control(op16), .A(a16), .B(b16),
        .ALU_result(r16), .ALU_result_hi(h16), .zero(z16), .overflow(o16),
        .div_by_zero(dz16), .illegal(il16), .busy(busy16), .done(done16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one op; operands are scrambled right after accept, an optional
    // stray start is raised at cycle 'poke', and another start is raised in the DONE cycle.
    task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int poke);
        @(negedge clk);
        op32 = op; a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0; op32 = ~op; a32 = ~a; b32 = ~b;
        lat  = 1;
        bcnt = busy32 ? 1 : 0;
        while (!done32 && lat < 100) begin
            start32 = (lat == poke);
            @(posedge clk); #1;
            lat++;
            if (busy32) bcnt++;
        end
        start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        check("idle_after_done", 64'({busy32, done32}), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start32 = 1'b1; op32 = 4'd0; a32 = 32'd1; b32 = 32'd1;
        start16 = 1'b0; op16 = 4'd0; a16 = 16'd0; b16 = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_done", 64'(done32), 64'd0);
        check("rst_outs", 64'({r32, h32, z32, o32, dz32, il32}), 64'd0);
        @(negedge clk);
        rst = 1'b0; start32 = 1'b0;
        @(posedge clk); #1;
        check("rst_start_ignored", 64'(busy32), 64'd0);

        run32(4'd0, 32'h7FFF_FFFF, 32'd1, 0);
        check("add_lat", 64'(lat), 64'd2);
        check("add_res", 64'(r32), 64'h8000_0000);
        check("add_ovf", 64'(o32), 64'd1);
        check("add_zero", 64'(z32), 64'd0);
        check("add_hi", 64'(h32), 64'd0);

        run32(4'd1, 32'd5, 32'd5, 0);
        check("sub_res", 64'(r32), 64'd0);
        check("sub_zero", 64'(z32), 64'd1);
        check("sub_ovf", 64'(o32), 64'd0);

        run32(4'd1, 32'h8000_0000, 32'd1, 0);
        check("sub_wrap", 64'(r32), 64'h7FFF_FFFF);
        check("sub_wrap_ovf", 64'(o32), 64'd1);

        run32(4'd4, 32'hF0F0_F0F0, 32'h0F0F_0000, 0);
        check("nor_res", 64'(r32), 64'h0000_0F0F);
        check("nor_ovf", 64'(o32), 64'd0);

        run32(4'd5, 32'hFFFF_FFFF, 32'd1, 0);
        check("slt_res", 64'(r32), 64'd1);
        run32(4'd6, 32'hFFFF_FFFF, 32'd1, 0);
        check("sltu_res", 64'(r32), 64'd0);
        check("sltu_zero", 64'(z32), 64'd1);

        run32(4'd9, 32'h8000_0000, 32'h24, 0);
        check("sra_res", 64'(r32), 64'hF800_0000);
        run32(4'd8, 32'h8000_0000, 32'h24, 0);
        check("srl_res", 64'(r32), 64'h0800_0000);
        run32(4'd7, 32'd1, 32'h3F, 0);
        check("sll_res", 64'(r32), 64'h8000_0000);

        run32(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10);
        check("mulu_lat", 64'(lat), 64'd33);
        check("mulu_busy_cycles", 64'(bcnt), 64'd33);
        check("mulu_hi", 64'(h32), 64'hFFFF_FFFE);
        check("mulu_lo", 64'(r32), 64'h0000_0001);
        check("mulu_zero", 64'(z32), 64'd0);

        run32(4'd11, 32'd100, 32'd7, 0);
        check("divu_lat", 64'(lat), 64'd33);
        check("divu_quo", 64'(r32), 64'd14);
        check("divu_rem", 64'(h32), 64'd2);
        check("divu_dbz", 64'(dz32), 64'd0);

        run32(4'd11, 32'hFFFF_FFFF, 32'h10, 0);
        check("divu_big_quo", 64'(r32), 64'h0FFF_FFFF);
        check("divu_big_rem", 64'(h32), 64'hF);

        run32(4'd11, 32'd100, 32'd0, 0);
        check("div0_lat", 64'(lat), 64'd2);
        check("div0_flag", 64'(dz32), 64'd1);
        check("div0_quo", 64'(r32), 64'hFFFF_FFFF);
        check("div0_rem", 64'(h32), 64'd100);

        // Abort a MULU with reset sampled on its tenth iteration edge.
        @(negedge clk);
        op32 = 4'd10; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_outs", 64'({r32, z32, o32, dz32, il32}), 64'd0);
        check("abort_hi", 64'(h32), 64'd0);
        check("abort_busy", 64'(busy32), 64'd0);
        check("abort_done", 64'(done32), 64'd0);
        dcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32 || busy32) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);

        run32(4'd0, 32'd3, 32'd4, 0);
        check("post_abort_add", 64'(r32), 64'd7);
        check("post_abort_lat", 64'(lat), 64'd2);

        run32(4'd13, 32'd5, 32'd6, 0);
        check("ill_flag", 64'(il32), 64'd1);
        check("ill_res", 64'(r32), 64'd0);
        check("ill_zero", 64'(z32), 64'd1);
        check("ill_lat", 64'(lat), 64'd2);

        @(negedge clk);
        op16 = 4'd10; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0; a16 = 16'd0; b16 = 16'd0;
        lat = 1;
        while (!done16 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("mulu16_lat", 64'(lat), 64'd17);
        check("mulu16_hi", 64'(h16), 64'hFFFE);
        check("mulu16_lo", 64'(r16), 64'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the single-cycle datapath ALU. It adds signed and unsigned compare, shifts, and iterative unsigned multiply and divide, plus status flags. Operations are launched with a start/busy/done handshake: the multi-cycle control unit issues an operation and stalls the pipeline until `done`. It sits between the register-file read ports and the writeback mux.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4 and a power of two.
- `SHW`, default $clog2(WIDTH): shift-amount width, derived; not to be overridden.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  launch request; accepted only when `busy`=0.
- `ALU_control`  input  4  opcode; sampled at accept.
- `A`, `B`  input  WIDTH each  operands; sampled at accept.
- `ALU_result`  output  WIDTH  primary result (low product, quotient).
- `ALU_result_hi`  output  WIDTH  high product or remainder; 0 for other ops.
- `zero`  output  1  `ALU_result`==0.
- `overflow`  output  1  signed overflow for ADD/SUB; 0 otherwise.
- `div_by_zero`  output  1  DIVU with B==0.
- `illegal`  output  1  opcode 12–15.
- `busy`  output  1  operation in flight.
- `done`  output  1  one-cycle pulse when results become valid.

## Operation
- Opcodes: 0 ADD A+B; 1 SUB A−B; 2 AND; 3 OR; 4 NOR; 5 SLT (signed A<B → 1 else 0); 6 SLTU (unsigned); 7 SLL A<<B[SHW-1:0]; 8 SRL (logical); 9 SRA (arithmetic); 10 MULU ({hi,lo} = A×B, unsigned, 2·WIDTH bits); 11 DIVU (lo = A/B, hi = A%B, unsigned); 12–15 illegal.
- ADD/SUB wrap modulo 2^WIDTH. `overflow` is set when the sign of the result disagrees with the sign implied by the operand signs (for SUB, use the inverted sign of B).
- Operands and opcode are captured into internal registers at accept. Later changes to `A`, `B` or `ALU_control` have no effect on the operation in flight.
- FSM states and transitions:
  - IDLE → EXEC on accept (`start`=1 in IDLE).
  - EXEC → DONE after 1 cycle for opcodes 0–9 and 12–15. For 10–11, EXEC → DONE after WIDTH cycles, one iteration per cycle, using a counter that loads WIDTH−1 and stops at 0.
  - DONE → IDLE unconditionally.
- MULU iteration: shift-add over the bits of B, LSB first.
- DIVU iteration: restoring, one quotient bit per cycle, MSB first. If B==0: skip iteration (EXEC 1 cycle), quotient = all ones, remainder = A, `div_by_zero`=1.
- Illegal opcode: EXEC 1 cycle, all results 0, `zero`=1, `illegal`=1.
- Result and flag outputs update only on the EXEC→DONE edge. They hold their values until the next operation's EXEC→DONE edge; the internal accumulator is not visible at the outputs.
- `start` while `busy`=1 is ignored (not queued).

## Timing
- `busy` = state≠IDLE (registered). It rises the cycle after accept and falls when DONE → IDLE.
- `done`=1 exactly in the DONE state.
- Latency from the accept edge to `done` high:
  - single-cycle ops and DIVU with B==0: 2 cycles;
  - MULU/DIVU: WIDTH+1 cycles.
- Peak issue rate: one op every 3 cycles for single-cycle ops, WIDTH+2 cycles for iterative ops.
- Reset (any state, including mid-iteration): state←IDLE, counter←0, all result/flag outputs←0, `busy`=0, `done`=0.
  - An aborted operation produces no `done`.
  - `start` in the reset cycle is ignored.
- `start` in the same cycle as DONE → IDLE is ignored; the earliest re-accept is the cycle in IDLE.

## Test plan
- Reset, then ADD A=0x7FFFFFFF, B=1 → after 2 cycles `done` pulse: result 0x80000000, `overflow`=1, `zero`=0. Then SUB 5−5 → result 0, `zero`=1, `overflow`=0.
- SLT A=0xFFFFFFFF, B=1 → 1; SLTU same operands → 0. SRA 0x80000000 by B=0x24 (amount 4) → 0xF8000000; SRL same → 0x08000000.
- MULU A=0xFFFFFFFF, B=0xFFFFFFFF → `done` exactly 33 cycles after accept, hi=0xFFFFFFFE, lo=0x00000001. `busy` is high for 33 cycles; a `start` pulse mid-run is ignored.
- DIVU 100/7 → quotient 14, remainder 2 at 33 cycles. DIVU 100/0 → `div_by_zero`=1, quotient 0xFFFFFFFF, remainder 100, `done` at 2 cycles.
- Assert `rst` in iteration 10 of MULU → next cycle all outputs 0, `busy`=0, no `done`. A new ADD 3+4 then completes with 7.
- Opcode 13 → `illegal`=1, result 0, `zero`=1. Re-run at WIDTH=16: MULU 0xFFFF×0xFFFF → hi 0xFFFE, lo 0x0001, latency 17.
